eth_phy_link_ctrl: RTL and testbench
====================================

Name: eth_phy_link_ctrl

Overview:
Link bring-up and recovery sequencer for the 10G PHY receive path, in the rx_clk domain. Holds the PHY and SERDES in reset, then releases them. Waits for block lock and a clear BER, and qualifies link stability before declaring link-up. On lock loss, high BER or a SERDES reset request it retries a bounded number of times, then reports failure. While the link is up it accumulates PHY RX error counts.

Parameters:
LOCK_TIMEOUT, 16384, rx_clk cycles allowed in WAIT_LOCK before a retry.
RESET_CYCLES, 32, cycles phy_rst/serdes_reset are held in PHY_RESET (minimum 1).
STABLE_CYCLES, 1024, consecutive good cycles required before link-up (minimum 1).
MAX_RETRIES, 7, recovery attempts before FAIL (1..15).
PRBS_CYCLES, 4096, PRBS31 check window length (used only with the optional feature).

Ports:
rx_clk  in  1  single clock
rx_rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run bring-up; 0 = force IDLE
rx_block_lock  in  1  from PHY
rx_high_ber  in  1  from PHY
rx_status  in  1  from PHY
rx_error_count  in  7  per-cycle error count from PHY
serdes_rx_reset_req  in  1  PHY request to reset the SERDES
err_clear  in  1  clear the error accumulator
phy_rst  out  1  active-high reset to the PHY rx/tx
serdes_reset  out  1  active-high SERDES reset
cfg_prbs31_enable  out  1  drives PHY cfg_tx/rx_prbs31_enable
link_up  out  1  link qualified
link_fail  out  1  retries exhausted
state  out  3  current state encoding
retry_count  out  4  attempts since last link-up
err_accum  out  32  saturating error sum

Behaviour:
- Reset (rx_rst_n=0, async): state=IDLE, phy_rst=1, serdes_reset=0, cfg_prbs31_enable=0, link_up=0, link_fail=0, retry_count=0, err_accum=0, all timers 0.
- State encodings: IDLE=0, PHY_RESET=1, WAIT_LOCK=2, STABLE=3, PRBS_CHECK=4, LINK_UP=5, RECOVER=6, FAIL=7.
- All outputs are registered and decoded from the registered state. Changes are visible the cycle after the triggering input.
- good = rx_block_lock & ~rx_high_ber.
- Highest priority: enable=0 forces IDLE on the next edge from any state. The timer is cleared; retry_count and err_accum are kept.
- IDLE: phy_rst=1. On enable=1: go to PHY_RESET, retry_count<=0.
- PHY_RESET: phy_rst=1 and serdes_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - Timer increments each cycle.
  - good -> STABLE, timer cleared.
  - Else timer==LOCK_TIMEOUT-1 -> RECOVER.
  - good on the timeout cycle: the good transition wins.
- STABLE:
  - Counts consecutive cycles with good & rx_status.
  - Any bad cycle -> WAIT_LOCK, timer cleared.
  - Count reaches STABLE_CYCLES -> PRBS_CHECK (feature on) or LINK_UP.
- LINK_UP:
  - link_up=1; retry_count<=0 on entry.
  - ~good or serdes_rx_reset_req -> RECOVER.
  - link_up drops the cycle RECOVER is entered.
- serdes_rx_reset_req in WAIT_LOCK or STABLE also goes to RECOVER. It is ignored in IDLE, PHY_RESET and FAIL.
- RECOVER (one cycle):
  - retry_count == MAX_RETRIES-1 -> FAIL; retry_count saturates at MAX_RETRIES.
  - Else retry_count+1 -> PHY_RESET.
- FAIL: link_fail=1, phy_rst=1; held until enable=0.
- err_accum:
  - In LINK_UP, adds zero-extended rx_error_count each cycle, saturating at 32'hFFFFFFFF.
  - err_clear alone -> 0.
  - err_clear while adding -> loads the current rx_error_count.
  - Frozen outside LINK_UP.

Optional Feature:
Macro ETH_LINK_CTRL_PRBS_EN.
- Defined: after STABLE the FSM enters PRBS_CHECK with cfg_prbs31_enable=1 for PRBS_CYCLES cycles, summing rx_error_count into a 16-bit saturating window sum.
  - Window ends with sum==0 -> LINK_UP.
  - Window ends with sum nonzero, or ~good during the window -> RECOVER.
  - cfg_prbs31_enable returns to 0 the cycle after leaving PRBS_CHECK.
- Not defined: PRBS_CHECK is unreachable, cfg_prbs31_enable is constant 0, and PRBS_CYCLES is unused.

Decomposition:
- Package eth_phy_link_pkg: state enum/localparams (3-bit), ERR_ACCUM_W=32, RETRY_W=4.
- One natural sub-module, eth_link_timer: a loadable, clearable cycle counter with a terminal-count flag. One instance is shared by PHY_RESET, WAIT_LOCK, STABLE and PRBS_CHECK.
- Saturating adders stay inline.

Test Plan:
Use LOCK_TIMEOUT=64, RESET_CYCLES=4, STABLE_CYCLES=8, MAX_RETRIES=2, PRBS_CYCLES=16 for all scenarios.
1. Bring-up: rx_rst_n released, enable=1, rx_block_lock=1 from cycle 10, rx_high_ber=0, rx_status=1 -> serdes_reset high exactly 4 cycles, STABLE entered, link_up=1 after 8 good cycles, state=5, retry_count=0.
2. Lock timeout: rx_block_lock held 0 -> RECOVER after 64 WAIT_LOCK cycles; second timeout -> state=7, link_fail=1, retry_count=2; enable=0 -> IDLE next cycle, link_fail=0.
3. Glitch in STABLE: lock drops for 1 cycle at STABLE count 5 -> back to WAIT_LOCK; link_up only after a fresh 8 consecutive good cycles.
4. Link loss: in LINK_UP, rx_high_ber=1 -> link_up=0 next cycle, state 6 then 1; relock -> link_up=1, retry_count=0. Repeat with serdes_rx_reset_req pulse -> same sequence.
5. Error accumulation: in LINK_UP, drive rx_error_count=127 for 3 cycles -> err_accum=381. Preload near saturation -> holds at 32'hFFFFFFFF. err_clear with rx_error_count=5 -> 5.
6. With ETH_LINK_CTRL_PRBS_EN: error-free window -> cfg_prbs31_enable=1 for 16 cycles, then link_up=1. One cycle of rx_error_count=1 in the window -> RECOVER, retry_count=1.

Source files
------------

// File: rtl/eth_phy_link_pkg.sv
// Shared constants for the 10G PHY receive link sequencer: state encodings and widths.
package eth_phy_link_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PHY_RESET  = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd2;
  localparam logic [2:0] S_STABLE     = 3'd3;
  localparam logic [2:0] S_PRBS_CHECK = 3'd4;
  localparam logic [2:0] S_LINK_UP    = 3'd5;
  localparam logic [2:0] S_RECOVER    = 3'd6;
  localparam logic [2:0] S_FAIL       = 3'd7;

  localparam int ERR_ACCUM_W = 32;
  localparam int RETRY_W     = 4;
  localparam int TIMER_W     = 16;
  localparam int PRBS_SUM_W  = 16;

endpackage

// File: rtl/eth_link_timer.sv
// Loadable, clearable cycle counter with a terminal-count flag; one instance serves every timed state.
module eth_link_timer
  import eth_phy_link_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over load, load wins over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/eth_phy_link_ctrl.sv
// Link bring-up / recovery sequencer for the 10G PHY receive path (rx_clk domain).
// Optional PRBS31 qualification window is built when ETH_LINK_CTRL_PRBS_EN is defined.
module eth_phy_link_ctrl
  import eth_phy_link_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 16384,
  parameter int RESET_CYCLES  = 32,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int PRBS_CYCLES   = 4096
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic        enable,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  input  logic        rx_status,
  input  logic [6:0]  rx_error_count,
  input  logic        serdes_rx_reset_req,
  input  logic        err_clear,
  output logic        phy_rst,
  output logic        serdes_reset,
  output logic        cfg_prbs31_enable,
  output logic        link_up,
  output logic        link_fail,
  output logic [2:0]  state,
  output logic [3:0]  retry_count,
  output logic [31:0] err_accum
);

  localparam logic [TIMER_W-1:0] RESET_TC  = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_TC   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_TC = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PRBS_TC   = TIMER_W'(PRBS_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = {{(RETRY_W-1){1'b0}}, 1'b1};

  logic [2:0]             state_q, state_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [ERR_ACCUM_W-1:0] err_accum_q, err_accum_d;
  logic [ERR_ACCUM_W:0]   err_sum_s;
  logic                   phy_rst_q, phy_rst_d;
  logic                   serdes_reset_q, serdes_reset_d;
  logic                   prbs_en_q, prbs_en_d;
  logic                   link_up_q, link_up_d;
  logic                   link_fail_q, link_fail_d;
  logic                   good_s, stable_ok_s, adding_s;
  logic                   timer_clr_s, timer_en_s, timer_tc_s;
  logic [TIMER_W-1:0]     timer_tc_val_s;

  assign good_s      = rx_block_lock & ~rx_high_ber;
  assign stable_ok_s = good_s & rx_status;
  assign adding_s    = (state_q == S_LINK_UP);

`ifdef ETH_LINK_CTRL_PRBS_EN
  logic [PRBS_SUM_W-1:0] prbs_sum_q, prbs_sum_d, prbs_sum_next_s;
  logic [PRBS_SUM_W:0]   prbs_raw_s;

  // Window sum restarts whenever the FSM is outside PRBS_CHECK.
  always_comb begin
    prbs_raw_s      = {1'b0, prbs_sum_q} + {{(PRBS_SUM_W-6){1'b0}}, rx_error_count};
    prbs_sum_next_s = prbs_raw_s[PRBS_SUM_W] ? {PRBS_SUM_W{1'b1}} : prbs_raw_s[PRBS_SUM_W-1:0];
    prbs_sum_d      = (state_q == S_PRBS_CHECK) ? prbs_sum_next_s : {PRBS_SUM_W{1'b0}};
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      prbs_sum_q <= {PRBS_SUM_W{1'b0}};
    end else begin
      prbs_sum_q <= prbs_sum_d;
    end
  end
`endif

  // Next-state and retry bookkeeping; enable=0 overrides everything.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PHY_RESET;
          retry_d = {RETRY_W{1'b0}};
        end
        S_PHY_RESET: begin
          if (timer_tc_s) state_d = S_WAIT_LOCK;
          else            state_d = S_PHY_RESET;
        end
        S_WAIT_LOCK: begin
          if (serdes_rx_reset_req) state_d = S_RECOVER;
          else if (good_s)         state_d = S_STABLE;
          else if (timer_tc_s)     state_d = S_RECOVER;
          else                     state_d = S_WAIT_LOCK;
        end
        S_STABLE: begin
          if (serdes_rx_reset_req) begin
            state_d = S_RECOVER;
          end else if (!stable_ok_s) begin
            state_d = S_WAIT_LOCK;
          end else if (timer_tc_s) begin
`ifdef ETH_LINK_CTRL_PRBS_EN
            state_d = S_PRBS_CHECK;
`else
            state_d = S_LINK_UP;
            retry_d = {RETRY_W{1'b0}};
`endif
          end else begin
            state_d = S_STABLE;
          end
        end
`ifdef ETH_LINK_CTRL_PRBS_EN
        S_PRBS_CHECK: begin
          if (!good_s) begin
            state_d = S_RECOVER;
          end else if (timer_tc_s) begin
            if (prbs_sum_next_s == {PRBS_SUM_W{1'b0}}) begin
              state_d = S_LINK_UP;
              retry_d = {RETRY_W{1'b0}};
            end else begin
              state_d = S_RECOVER;
            end
          end else begin
            state_d = S_PRBS_CHECK;
          end
        end
`endif
        S_LINK_UP: begin
          if (!good_s || serdes_rx_reset_req) state_d = S_RECOVER;
          else                                state_d = S_LINK_UP;
        end
        S_RECOVER: begin
          if (retry_q >= RETRY_LAST) begin
            state_d = S_FAIL;
            retry_d = RETRY_MAX;
          end else begin
            state_d = S_PHY_RESET;
            retry_d = retry_q + RETRY_ONE;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Every state change restarts the shared timer so each timed state begins at zero.
  always_comb begin
    timer_clr_s    = (state_d != state_q);
    timer_en_s     = 1'b0;
    timer_tc_val_s = {TIMER_W{1'b0}};
    case (state_q)
      S_PHY_RESET:  begin timer_en_s = 1'b1; timer_tc_val_s = RESET_TC;  end
      S_WAIT_LOCK:  begin timer_en_s = 1'b1; timer_tc_val_s = LOCK_TC;   end
      S_STABLE:     begin timer_en_s = 1'b1; timer_tc_val_s = STABLE_TC; end
      S_PRBS_CHECK: begin timer_en_s = 1'b1; timer_tc_val_s = PRBS_TC;   end
      default:      begin timer_en_s = 1'b0; timer_tc_val_s = {TIMER_W{1'b0}}; end
    endcase
  end

  eth_link_timer #(.W(TIMER_W)) u_timer (
    .clk      (rx_clk),
    .rst_n    (rx_rst_n),
    .clr      (timer_clr_s),
    .en       (timer_en_s),
    .load     (1'b0),
    .load_val ({TIMER_W{1'b0}}),
    .tc_val   (timer_tc_val_s),
    .tc       (timer_tc_s)
  );

  // Saturating error accumulator; clear while adding loads the current count.
  always_comb begin
    err_sum_s = {1'b0, err_accum_q} + {{(ERR_ACCUM_W-6){1'b0}}, rx_error_count};
    if (err_clear) begin
      err_accum_d = adding_s ? {{(ERR_ACCUM_W-7){1'b0}}, rx_error_count} : {ERR_ACCUM_W{1'b0}};
    end else if (adding_s) begin
      err_accum_d = err_sum_s[ERR_ACCUM_W] ? {ERR_ACCUM_W{1'b1}} : err_sum_s[ERR_ACCUM_W-1:0];
    end else begin
      err_accum_d = err_accum_q;
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    phy_rst_d      = (state_d == S_IDLE) || (state_d == S_PHY_RESET) || (state_d == S_FAIL);
    serdes_reset_d = (state_d == S_PHY_RESET);
    link_up_d      = (state_d == S_LINK_UP);
    link_fail_d    = (state_d == S_FAIL);
`ifdef ETH_LINK_CTRL_PRBS_EN
    prbs_en_d      = (state_d == S_PRBS_CHECK);
`else
    prbs_en_d      = 1'b0;
`endif
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q        <= S_IDLE;
      retry_q        <= {RETRY_W{1'b0}};
      err_accum_q    <= {ERR_ACCUM_W{1'b0}};
      phy_rst_q      <= 1'b1;
      serdes_reset_q <= 1'b0;
      prbs_en_q      <= 1'b0;
      link_up_q      <= 1'b0;
      link_fail_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      err_accum_q    <= err_accum_d;
      phy_rst_q      <= phy_rst_d;
      serdes_reset_q <= serdes_reset_d;
      prbs_en_q      <= prbs_en_d;
      link_up_q      <= link_up_d;
      link_fail_q    <= link_fail_d;
    end
  end

  assign phy_rst           = phy_rst_q;
  assign serdes_reset      = serdes_reset_q;
  assign cfg_prbs31_enable = prbs_en_q;
  assign link_up           = link_up_q;
  assign link_fail         = link_fail_q;
  assign state             = state_q;
  assign retry_count       = retry_q;
  assign err_accum         = err_accum_q;

endmodule

// File: tb/tb_eth_phy_link_ctrl.sv
// Directed, table-driven bench for eth_phy_link_ctrl with small test parameters.
module tb_eth_phy_link_ctrl;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n;
  logic        enable;
  logic        rx_block_lock;
  logic        rx_high_ber;
  logic        rx_status;
  logic [6:0]  rx_error_count;
  logic        serdes_rx_reset_req;
  logic        err_clear;
  logic        phy_rst;
  logic        serdes_reset;
  logic        cfg_prbs31_enable;
  logic        link_up;
  logic        link_fail;
  logic [2:0]  state;
  logic [3:0]  retry_count;
  logic [31:0] err_accum;

  int n_cmp = 0;
  int n_bad = 0;

  eth_phy_link_ctrl #(
    .LOCK_TIMEOUT (64),
    .RESET_CYCLES (4),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .PRBS_CYCLES  (16)
  ) dut (
    .rx_clk             (rx_clk),
    .rx_rst_n           (rx_rst_n),
    .enable             (enable),
    .rx_block_lock      (rx_block_lock),
    .rx_high_ber        (rx_high_ber),
    .rx_status          (rx_status),
    .rx_error_count     (rx_error_count),
    .serdes_rx_reset_req(serdes_rx_reset_req),
    .err_clear          (err_clear),
    .phy_rst            (phy_rst),
    .serdes_reset       (serdes_reset),
    .cfg_prbs31_enable  (cfg_prbs31_enable),
    .link_up            (link_up),
    .link_fail          (link_fail),
    .state              (state),
    .retry_count        (retry_count),
    .err_accum          (err_accum)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic       en;
    logic       lock;
    logic       ber;
    logic       req;
    logic [2:0] st;
    logic [3:0] rt;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {phy_rst, serdes_reset, cfg_prbs31_enable, link_up, link_fail} for a state.
  function automatic logic [4:0] exp_outs(input logic [2:0] st);
    exp_outs = {(st == 3'd0) || (st == 3'd1) || (st == 3'd7), st == 3'd1, st == 3'd4,
                st == 3'd5, st == 3'd7};
  endfunction

  function automatic logic [4:0] act_outs();
    act_outs = {phy_rst, serdes_reset, cfg_prbs31_enable, link_up, link_fail};
  endfunction

  task automatic add(input int n, input logic en, input logic lock, input logic ber,
                     input logic req, input logic [2:0] st, input logic [3:0] rt);
    vec_t v;
    v.en = en; v.lock = lock; v.ber = ber; v.req = req; v.st = st; v.rt = rt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic add_prbs(input logic [3:0] rt);
`ifdef ETH_LINK_CTRL_PRBS_EN
    add(16, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, rt);
`else
    add(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, rt);
`endif
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int bound);
    int n;
    n = 0;
    while (state !== s && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic count_in_state(input string name, input logic [2:0] s, input int exp_n);
    int n;
    n = 0;
    while (state === s && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    rx_rst_n = 1'b0; enable = 1'b0; rx_block_lock = 1'b0; rx_high_ber = 1'b0;
    rx_status = 1'b1; rx_error_count = 7'd0; serdes_rx_reset_req = 1'b0; err_clear = 1'b0;

    // Bring-up, BER loss and SERDES-request loss, each followed by relock.
    add(4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0);
    add(5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0);
    add(8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd0);
    add_prbs(4'd0);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 4'd0);
    add(4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd1);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd1);
    add(8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd1);
    add_prbs(4'd1);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0);
    add(1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 4'd0);
    add(4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd1);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd1);
    add(8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd1);
    add_prbs(4'd1);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0);

    #12;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(act_outs()), 32'(5'b10000));
    check("reset_retry", 32'(retry_count), 32'd0);
    check("reset_err", err_accum, 32'd0);
    tick();
    rx_rst_n = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; rx_block_lock = vecs[i].lock;
      rx_high_ber = vecs[i].ber; serdes_rx_reset_req = vecs[i].req;
      tick();
      check($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("row%0d_outs", i), 32'(act_outs()), 32'(exp_outs(vecs[i].st)));
      check($sformatf("row%0d_retry", i), 32'(retry_count), 32'(vecs[i].rt));
    end
    serdes_rx_reset_req = 1'b0;

    // Error accumulation in LINK_UP, saturation and clear.
    rx_error_count = 7'd127;
    repeat (3) tick();
    rx_error_count = 7'd0;
    check("err_381", err_accum, 32'd381);
    force dut.err_accum_q = 32'hFFFF_FF00;
    #1;
    release dut.err_accum_q;
    rx_error_count = 7'd127;
    tick();
    tick();
    check("err_near_sat", err_accum, 32'hFFFF_FFFE);
    tick();
    check("err_sat", err_accum, 32'hFFFF_FFFF);
    tick();
    check("err_sat_hold", err_accum, 32'hFFFF_FFFF);
    rx_error_count = 7'd5; err_clear = 1'b1;
    tick();
    err_clear = 1'b0; rx_error_count = 7'd0;
    check("err_clear_load", err_accum, 32'd5);

    // Lock timeout twice -> FAIL; err_accum frozen outside LINK_UP.
    enable = 1'b0;
    tick();
    check("dis_state", 32'(state), 32'd0);
    check("dis_link_up", 32'(link_up), 32'd0);
    rx_block_lock = 1'b0; rx_error_count = 7'd3; enable = 1'b1;
    tick();
    check("to_phy_reset", 32'(state), 32'd1);
    wait_state("to_wait1", 3'd2, 10);
    count_in_state("wait1_len", 3'd2, 64);
    check("recover1", 32'(state), 32'd6);
    tick();
    check("retry1", 32'(retry_count), 32'd1);
    wait_state("to_wait2", 3'd2, 10);
    count_in_state("wait2_len", 3'd2, 64);
    tick();
    check("fail_state", 32'(state), 32'd7);
    check("fail_outs", 32'(act_outs()), 32'(5'b10001));
    check("fail_retry", 32'(retry_count), 32'd2);
    repeat (3) tick();
    check("fail_hold", 32'(state), 32'd7);
    check("err_frozen", err_accum, 32'd5);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_clear_idle", err_accum, 32'd0);
    enable = 1'b0;
    tick();
    check("fail_exit_state", 32'(state), 32'd0);
    check("fail_exit_lf", 32'(link_fail), 32'd0);
    check("fail_exit_retry", 32'(retry_count), 32'd2);
    rx_error_count = 7'd0;

    // One-cycle lock glitch in STABLE restarts qualification.
    rx_block_lock = 1'b1; enable = 1'b1;
    tick();
    check("glitch_retry0", 32'(retry_count), 32'd0);
    wait_state("glitch_stable", 3'd3, 20);
    repeat (4) tick();
    check("glitch_pre", 32'(state), 32'd3);
    rx_block_lock = 1'b0;
    tick();
    check("glitch_wait", 32'(state), 32'd2);
    rx_block_lock = 1'b1;
    tick();
    check("glitch_restable", 32'(state), 32'd3);
    repeat (7) tick();
    check("glitch_not_yet", 32'(act_outs()), 32'(exp_outs(3'd3)));
    tick();
`ifdef ETH_LINK_CTRL_PRBS_EN
    check("prbs_enter", 32'(act_outs()), 32'(exp_outs(3'd4)));
    count_in_state("prbs_len", 3'd4, 16);
    check("prbs_pass", 32'(act_outs()), 32'(exp_outs(3'd5)));
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_state("prbs2_enter", 3'd4, 40);
    rx_error_count = 7'd1;
    tick();
    rx_error_count = 7'd0;
    wait_state("prbs2_recover", 3'd6, 40);
    tick();
    check("prbs2_state", 32'(state), 32'd1);
    check("prbs2_retry", 32'(retry_count), 32'd1);
    check("prbs2_cfg_off", 32'(cfg_prbs31_enable), 32'd0);
`else
    check("glitch_link_up", 32'(act_outs()), 32'(exp_outs(3'd5)));
    check("glitch_state", 32'(state), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
